// File: rtl/interleave_l2_mux.sv
// Level-2 interleave mux: takes a lane pair from the L1 stage and serializes it
// as lane 0 then lane 1 onto an 8-bit output. Invalid lanes are skipped.
// Outputs are Moore and come from the state and hold registers only.
module interleave_l2_mux (
  input  logic       clk_4f,
  input  logic       reset_L,
  input  logic       in_load,
  input  logic       valid0_in,
  input  logic       valid1_in,
  input  logic [7:0] data0_in,
  input  logic [7:0] data1_in,
  output logic       in_ready,
  output logic       valid_out,
  output logic [7:0] data_out,
  output logic       lane_sel,
  output logic [7:0] byte_count
);

  typedef enum logic [1:0] {StIdle, StSend0, StSend1} state_e;

  state_e     state_q, state_d;
  logic       hv0_q, hv1_q;
  logic [7:0] hd0_q, hd1_q;
  logic [7:0] byte_count_q;
  logic       accept;

  // Ready whenever the current cycle is the last byte of the held pair (or nothing is held).
  always_comb begin
    in_ready = 1'b0;
    if (reset_L) begin
      unique case (state_q)
        StIdle:  in_ready = 1'b1;
        StSend0: in_ready = ~hv1_q;
        StSend1: in_ready = 1'b1;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_load & in_ready;

  // Next state: a new accept takes priority so a last-send cycle chains without a bubble.
  always_comb begin
    state_d = StIdle;
    if (accept) begin
      if (valid0_in) begin
        state_d = StSend0;
      end else if (valid1_in) begin
        state_d = StSend1;
      end else begin
        state_d = StIdle;
      end
    end else begin
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StSend0: state_d = hv1_q ? StSend1 : StIdle;
        StSend1: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Moore outputs decoded from state and hold registers.
  always_comb begin
    valid_out = 1'b0;
    data_out  = 8'h00;
    lane_sel  = 1'b0;
    unique case (state_q)
      StIdle: begin
        valid_out = 1'b0;
      end
      StSend0: begin
        valid_out = hv0_q;
        data_out  = hd0_q;
        lane_sel  = 1'b0;
      end
      StSend1: begin
        valid_out = hv1_q;
        data_out  = hd1_q;
        lane_sel  = 1'b1;
      end
      default: begin
        valid_out = 1'b0;
      end
    endcase
  end

  assign byte_count = byte_count_q;

  // State, hold registers and emitted-byte counter; reset discards any in-flight pair.
  always_ff @(posedge clk_4f) begin
    if (!reset_L) begin
      state_q      <= StIdle;
      hv0_q        <= 1'b0;
      hv1_q        <= 1'b0;
      hd0_q        <= 8'h00;
      hd1_q        <= 8'h00;
      byte_count_q <= 8'h00;
    end else begin
      state_q <= state_d;
      if (accept) begin
        hv0_q <= valid0_in;
        hv1_q <= valid1_in;
        hd0_q <= data0_in;
        hd1_q <= data1_in;
      end
      if (valid_out) begin
        byte_count_q <= byte_count_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_interleave_l2_mux.sv
// Self-checking bench for interleave_l2_mux. The reference model is a queue of
// pending {lane, byte} entries: the head is what the output shows this cycle.
module tb_interleave_l2_mux;

  logic       clk_4f = 1'b0;
  logic       reset_L;
  logic       in_load;
  logic       valid0_in;
  logic       valid1_in;
  logic [7:0] data0_in;
  logic [7:0] data1_in;
  logic       in_ready;
  logic       valid_out;
  logic [7:0] data_out;
  logic       lane_sel;
  logic [7:0] byte_count;

  int n_chk  = 0;
  int n_fail = 0;

  logic [8:0] mq[$];
  logic [7:0] m_count;
  logic [7:0] seen[6];
  logic [7:0] exp_seq[6];

  always #5 clk_4f = ~clk_4f;

  interleave_l2_mux dut (
    .clk_4f     (clk_4f),
    .reset_L    (reset_L),
    .in_load    (in_load),
    .valid0_in  (valid0_in),
    .valid1_in  (valid1_in),
    .data0_in   (data0_in),
    .data1_in   (data1_in),
    .in_ready   (in_ready),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .lane_sel   (lane_sel),
    .byte_count (byte_count)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, clock, advance the model.
  task automatic cycle(input logic ld, input logic v0, input logic v1,
                       input logic [7:0] d0, input logic [7:0] d1, input logic rst);
    logic       acc;
    logic       busy;
    logic [8:0] head;
    in_load   = ld;
    valid0_in = v0;
    valid1_in = v1;
    data0_in  = d0;
    data1_in  = d1;
    reset_L   = rst;
    #1;
    busy = (mq.size() != 0);
    head = busy ? mq[0] : 9'h000;
    chk("valid_out", {7'b0, valid_out}, {7'b0, busy});
    chk("data_out", data_out, head[7:0]);
    chk("lane_sel", {7'b0, lane_sel}, {7'b0, head[8]});
    chk("byte_count", byte_count, m_count);
    chk("in_ready", {7'b0, in_ready}, {7'b0, rst && (mq.size() <= 1)});
    @(posedge clk_4f);
    if (!rst) begin
      mq.delete();
      m_count = 8'h00;
    end else begin
      acc = ld && (mq.size() <= 1);
      if (busy) begin
        m_count++;
        void'(mq.pop_front());
      end
      if (acc) begin
        if (v0) mq.push_back({1'b0, d0});
        if (v1) mq.push_back({1'b1, d1});
      end
    end
    #1;
  endtask

  initial begin
    m_count   = 8'h00;
    reset_L   = 1'b0;
    in_load   = 1'b1;
    valid0_in = 1'b1;
    valid1_in = 1'b1;
    data0_in  = 8'hFF;
    data1_in  = 8'hFF;
    repeat (2) @(posedge clk_4f);
    #1;
    // Reset state, with in_load held high during reset
    chk("rst_valid_out", {7'b0, valid_out}, 8'h00);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_lane_sel", {7'b0, lane_sel}, 8'h00);
    chk("rst_byte_count", byte_count, 8'h00);
    chk("rst_in_ready", {7'b0, in_ready}, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    // Full pair A5/3C
    cycle(1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C, 1'b1);
    chk("pair_first_data", data_out, 8'hA5);
    chk("pair_first_lane", {7'b0, lane_sel}, 8'h00);
    chk("pair_ready_low", {7'b0, in_ready}, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("pair_second_data", data_out, 8'h3C);
    chk("pair_second_lane", {7'b0, lane_sel}, 8'h01);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("pair_done_valid", {7'b0, valid_out}, 8'h00);
    chk("pair_byte_count", byte_count, 8'h02);

    // Lane 0 invalid: only 7E, on lane 1, with no gap
    cycle(1'b1, 1'b0, 1'b1, 8'h99, 8'h7E, 1'b1);
    chk("skip0_valid", {7'b0, valid_out}, 8'h01);
    chk("skip0_data", data_out, 8'h7E);
    chk("skip0_lane", {7'b0, lane_sel}, 8'h01);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("skip0_done", {7'b0, valid_out}, 8'h00);
    chk("skip0_count", byte_count, 8'h03);

    // Both lanes invalid: dropped
    cycle(1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 1'b1);
    chk("drop_valid", {7'b0, valid_out}, 8'h00);
    chk("drop_ready", {7'b0, in_ready}, 8'h01);
    chk("drop_count", byte_count, 8'h03);

    // Back-to-back pairs with in_load held high; upstream holds a pair until accepted
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33;
    exp_seq[3] = 8'h44; exp_seq[4] = 8'h55; exp_seq[5] = 8'h66;
    cycle(1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 1'b1); seen[0] = valid_out ? data_out : 8'hXX;
    cycle(1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 1'b1); seen[1] = valid_out ? data_out : 8'hXX;
    cycle(1'b1, 1'b1, 1'b1, 8'h33, 8'h44, 1'b1); seen[2] = valid_out ? data_out : 8'hXX;
    cycle(1'b1, 1'b1, 1'b1, 8'h33, 8'h44, 1'b1); seen[3] = valid_out ? data_out : 8'hXX;
    cycle(1'b1, 1'b1, 1'b1, 8'h55, 8'h66, 1'b1); seen[4] = valid_out ? data_out : 8'hXX;
    cycle(1'b1, 1'b1, 1'b1, 8'h55, 8'h66, 1'b1); seen[5] = valid_out ? data_out : 8'hXX;
    for (int i = 0; i < 6; i++) chk("b2b_seq", seen[i], exp_seq[i]);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    // Reset during SEND0 of AA/BB, with in_load also high
    cycle(1'b1, 1'b1, 1'b1, 8'hAA, 8'hBB, 1'b1);
    chk("rst_mid_first", data_out, 8'hAA);
    cycle(1'b1, 1'b1, 1'b1, 8'hCC, 8'hDD, 1'b0);
    chk("rst_mid_valid", {7'b0, valid_out}, 8'h00);
    chk("rst_mid_data", data_out, 8'h00);
    chk("rst_mid_count", byte_count, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("rst_mid_no_bb", {7'b0, valid_out}, 8'h00);

    // 256 emitted bytes wraps byte_count
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 128; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 8'(i), 8'(~i), 1'b1);
      cycle(1'b1, 1'b1, 1'b1, 8'(i), 8'(~i), 1'b1);
    end
    chk("wrap_before", byte_count, 8'hFF);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("wrap_count", byte_count, 8'h00);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom), 8'($urandom), ($urandom_range(0, 39) != 0));
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/interleave_l2_mux.md
INTERLEAVE_L2_MUX -- requirements
Module: interleave_l2_mux

Interface
REQ-001 SHALL have no parameters; all widths are fixed at 8-bit data lanes.
REQ-002 SHALL provide port clk_4f, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset_L, input, 1 bit: synchronous active-low reset, sampled on the clk_4f rising edge.
REQ-004 SHALL provide port in_load, input, 1 bit: upstream presents a lane pair this cycle.
REQ-005 SHALL provide ports valid0_in and valid1_in, input, 1 bit each: per-lane valid from the L1 mux stage.
REQ-006 SHALL provide ports data0_in and data1_in, input, 8 bits each: lane 0 and lane 1 bytes from the L1 mux stage.
REQ-007 SHALL provide port in_ready, output, 1 bit: block accepts a pair at this edge if in_load=1.
REQ-008 SHALL provide port valid_out, output, 1 bit: data_out carries a valid byte.
REQ-009 SHALL provide port data_out, output, 8 bits: serialized byte.
REQ-010 SHALL provide port lane_sel, output, 1 bit: source lane of the current data_out (0 or 1).
REQ-011 SHALL provide port byte_count, output, 8 bits: count of bytes emitted with valid_out=1.

Function
REQ-012 SHALL implement FSM states IDLE, SEND0, SEND1; outputs SHALL be Moore (from state and hold registers only).
REQ-013 SHALL accept when in_load=1 and in_ready=1 at a rising edge, latching valid0_in, valid1_in, data0_in and data1_in into hold registers hv0, hv1, hd0 and hd1.
REQ-014 On accept, next state SHALL be SEND0 if valid0_in=1; SEND1 if valid0_in=0 and valid1_in=1; IDLE if both are 0, in which case the pair is dropped and no byte is emitted.
REQ-015 In SEND0: valid_out=1, data_out=hd0, lane_sel=0; next state SEND1 if hv1=1, else IDLE (or a new accept per REQ-014).
REQ-016 In SEND1: valid_out=1, data_out=hd1, lane_sel=1; next state IDLE unless a new accept occurs.
REQ-017 In IDLE: valid_out=0, data_out=8'h00, lane_sel=0.
REQ-018 in_ready SHALL be 1 when the state is IDLE, when it is SEND1, or when it is SEND0 with hv1=0; it SHALL be 0 when the state is SEND0 with hv1=1; it SHALL be forced 0 while reset_L=0.
REQ-019 An accept in a last-send cycle (SEND1, or SEND0 with hv1=0) SHALL take effect at that same edge, giving back-to-back output with no IDLE bubble.
REQ-020 Latency SHALL be 1 cycle: the first byte of an accepted pair appears on data_out in the cycle immediately after the accept edge.
REQ-021 Lane order SHALL always be lane 0 then lane 1; an invalid lane SHALL be skipped, never emitted as a valid_out=0 gap.
REQ-022 in_load=1 with in_ready=0 SHALL be ignored: inputs are not latched and upstream must hold them.
REQ-023 byte_count SHALL increment by 1 at each edge where valid_out=1, wrapping from 8'hFF to 8'h00.

Reset
REQ-024 With reset_L=0 at an edge, the block SHALL set state=IDLE; hv0, hv1, hd0, hd1 to 0; byte_count to 8'h00; and valid_out, data_out and lane_sel to 0 from the next cycle.
REQ-025 Reset SHALL override all other activity, including mid-SEND0 or SEND1 and simultaneous in_load; the in-flight pair SHALL be discarded.
REQ-026 in_load asserted while reset_L=0 SHALL NOT be accepted.

Verification
REQ-027 The bench SHALL cover: pair {v0=1,d0=8'hA5; v1=1,d1=8'h3C} accepted at edge N -> cycle N+1 data_out=A5, lane_sel=0; cycle N+2 data_out=3C, lane_sel=1; in_ready=0 during N+1; byte_count=2.
REQ-028 The bench SHALL cover: pair {v0=0; v1=1,d1=8'h7E} -> single cycle data_out=7E, lane_sel=1, with no lane-0 gap.
REQ-029 The bench SHALL cover: pair with v0=v1=0 -> valid_out stays 0, state stays IDLE, byte_count unchanged.
REQ-030 The bench SHALL cover: in_load held high with pairs {11,22}, {33,44}, {55,66} -> data_out sequence 11,22,33,44,55,66 on consecutive cycles, valid_out never drops.
REQ-031 The bench SHALL cover: reset_L=0 during SEND0 of pair {AA,BB} -> next cycle valid_out=0, data_out=00, byte_count=00, and BB is never emitted.
REQ-032 The bench SHALL cover: 256 emitted bytes -> byte_count wraps to 8'h00.
